// File: rtl/game_ctl.sv
// Game sequencer for the bug-catching game: screen selection, click/hit detection,
// score keeping, frame-based round timer and bug respawn requests.
module game_ctl #(
  parameter int unsigned BTN_X          = 412,
  parameter int unsigned BTN_Y          = 334,
  parameter int unsigned BTN_W          = 200,
  parameter int unsigned BTN_H          = 100,
  parameter int unsigned BUG_W          = 64,
  parameter int unsigned BUG_H          = 64,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned TIME_LIMIT     = 30,
  parameter int unsigned MAX_SCORE      = 99,
  parameter int unsigned HOLD_FRAMES    = 90
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        mouse_left,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [11:0] x_bugpos,
  input  logic [11:0] y_bugpos,
  output logic [1:0]  screen_sel,
  output logic        bug_enable,
  output logic        bug_respawn,
  output logic [6:0]  score,
  output logic [6:0]  time_left,
  output logic        game_over
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam int unsigned FW = (FRAMES_PER_SEC < 2) ? 1 : $clog2(FRAMES_PER_SEC);
  localparam int unsigned HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [12:0] BTN_X0 = 13'(BTN_X);
  localparam logic [12:0] BTN_X1 = 13'(BTN_X + BTN_W);
  localparam logic [12:0] BTN_Y0 = 13'(BTN_Y);
  localparam logic [12:0] BTN_Y1 = 13'(BTN_Y + BTN_H);

  localparam logic [6:0]    TL_INIT  = 7'(TIME_LIMIT);
  localparam logic [6:0]    SC_MAX   = 7'(MAX_SCORE);
  localparam logic [FW-1:0] FR_LAST  = FW'(FRAMES_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);

  logic [1:0]    state, state_n;
  logic          mouse_left_d, vsync_d;
  logic [FW-1:0] frame_cnt, frame_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [6:0]    score_n, time_n;
  logic          respawn_n;
  logic          click_c, tick_c, in_btn_c, in_bug_c;
  logic [12:0]   bug_x1_c, bug_y1_c;

  assign click_c  = mouse_left & ~mouse_left_d;
  assign tick_c   = vsync & ~vsync_d;
  assign bug_x1_c = {1'b0, x_bugpos} + 13'(BUG_W);
  assign bug_y1_c = {1'b0, y_bugpos} + 13'(BUG_H);

  // 13-bit compares so the far edges never wrap
  assign in_btn_c = ({1'b0, xpos} >= BTN_X0) && ({1'b0, xpos} < BTN_X1) &&
                    ({1'b0, ypos} >= BTN_Y0) && ({1'b0, ypos} < BTN_Y1);
  assign in_bug_c = ({1'b0, xpos} >= {1'b0, x_bugpos}) && ({1'b0, xpos} < bug_x1_c) &&
                    ({1'b0, ypos} >= {1'b0, y_bugpos}) && ({1'b0, ypos} < bug_y1_c);

  always_ff @(posedge pclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    score_n   = score;
    time_n    = time_left;
    frame_n   = frame_cnt;
    hold_n    = hold_cnt;
    respawn_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (click_c && in_btn_c) begin
          state_n   = S_PLAY;
          score_n   = 7'd0;
          time_n    = TL_INIT;
          frame_n   = '0;
          respawn_n = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick_c) begin
          if (frame_cnt == FR_LAST) begin
            frame_n = '0;
            if (time_left == 7'd1) begin
              time_n  = 7'd0;
              state_n = S_OVER;
              hold_n  = '0;
            end else begin
              time_n = time_left - 7'd1;
            end
          end else begin
            frame_n = frame_cnt + FW'(1);
          end
        end
        // A hit on the expiring tick still scores, but the bug is not respawned
        if (click_c && in_bug_c) begin
          if (score < SC_MAX) score_n = score + 7'd1;
          respawn_n = (state_n == S_PLAY);
        end
      end
      S_OVER: begin
        if (tick_c && (hold_cnt < HOLD_MAX)) hold_n = hold_cnt + HW'(1);
        if (click_c && (hold_cnt == HOLD_MAX)) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        score_n = 7'd0;
        time_n  = TL_INIT;
        frame_n = '0;
        hold_n  = '0;
      end
    endcase
  end

  // Datapath and registered outputs, all derived from the next state
  always_ff @(posedge pclk) begin
    if (rst) begin
      mouse_left_d <= 1'b1;
      vsync_d      <= 1'b1;
      frame_cnt    <= '0;
      hold_cnt     <= '0;
      score        <= 7'd0;
      time_left    <= TL_INIT;
      bug_respawn  <= 1'b0;
      screen_sel   <= 2'd0;
      bug_enable   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      mouse_left_d <= mouse_left;
      vsync_d      <= vsync;
      frame_cnt    <= frame_n;
      hold_cnt     <= hold_n;
      score        <= score_n;
      time_left    <= time_n;
      bug_respawn  <= respawn_n;
      screen_sel   <= (state_n == S_PLAY) ? 2'd1 : ((state_n == S_OVER) ? 2'd2 : 2'd0);
      bug_enable   <= (state_n == S_PLAY);
      game_over    <= (state_n == S_OVER);
    end
  end

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: a default-parameter instance and a short-round
// instance (2 s of 3 frames, 4-frame hold-off) share one stimulus stream.
module tb_game_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        vsync;
  logic        mouse_left;
  logic [11:0] xpos, ypos, x_bugpos, y_bugpos;

  logic [1:0] d_sel, s_sel;
  logic       d_en, s_en, d_rsp, s_rsp, d_go, s_go;
  logic [6:0] d_score, s_score, d_time, s_time;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  game_ctl u_dflt (
    .pclk(pclk), .rst(rst), .vsync(vsync), .mouse_left(mouse_left),
    .xpos(xpos), .ypos(ypos), .x_bugpos(x_bugpos), .y_bugpos(y_bugpos),
    .screen_sel(d_sel), .bug_enable(d_en), .bug_respawn(d_rsp),
    .score(d_score), .time_left(d_time), .game_over(d_go)
  );

  game_ctl #(.FRAMES_PER_SEC(3), .TIME_LIMIT(2), .HOLD_FRAMES(4)) u_short (
    .pclk(pclk), .rst(rst), .vsync(vsync), .mouse_left(mouse_left),
    .xpos(xpos), .ypos(ypos), .x_bugpos(x_bugpos), .y_bugpos(y_bugpos),
    .screen_sel(s_sel), .bug_enable(s_en), .bug_respawn(s_rsp),
    .score(s_score), .time_left(s_time), .game_over(s_go)
  );

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input int x, input int y);
    xpos = 12'(x);
    ypos = 12'(y);
    mouse_left = 1'b1;
    step();
  endtask

  task automatic release_btn();
    mouse_left = 1'b0;
    step();
  endtask

  task automatic tick();
    vsync = 1'b1;
    step();
    vsync = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; mouse_left = 1'b1;
    xpos = 12'd500; ypos = 12'd380; x_bugpos = 12'd300; y_bugpos = 12'd200;
    step(); step();

    // Reset values
    chk("rst_sel", 32'(d_sel), 0);
    chk("rst_en", 32'(d_en), 0);
    chk("rst_rsp", 32'(d_rsp), 0);
    chk("rst_score", 32'(d_score), 0);
    chk("rst_time", 32'(d_time), 30);
    chk("rst_go", 32'(d_go), 0);
    chk("rst_time_short", 32'(s_time), 2);

    // Button held through reset release on the start button: no click
    rst = 1'b0;
    step(); step();
    chk("held_sel", 32'(d_sel), 0);
    chk("held_rsp", 32'(d_rsp), 0);
    release_btn();

    // Click outside the button is ignored
    press(100, 100);
    chk("miss_btn_sel", 32'(d_sel), 0);
    chk("miss_btn_rsp", 32'(d_rsp), 0);
    release_btn();

    // Start the game
    press(500, 380);
    chk("start_sel", 32'(d_sel), 1);
    chk("start_en", 32'(d_en), 1);
    chk("start_rsp", 32'(d_rsp), 1);
    chk("start_score", 32'(d_score), 0);
    chk("start_time", 32'(d_time), 30);
    release_btn();
    chk("start_rsp_end", 32'(d_rsp), 0);
    chk("start_sel_hold", 32'(d_sel), 1);

    // Hits at the hit-box corners, then a miss just past the right edge
    press(330, 230);
    chk("hit1_score", 32'(d_score), 1);
    chk("hit1_rsp", 32'(d_rsp), 1);
    release_btn();
    chk("hit1_rsp_end", 32'(d_rsp), 0);
    press(363, 263);
    chk("hit2_score", 32'(d_score), 2);
    chk("hit2_rsp", 32'(d_rsp), 1);
    release_btn();
    press(364, 230);
    chk("miss_score", 32'(d_score), 2);
    chk("miss_rsp", 32'(d_rsp), 0);
    release_btn();

    // Short round: 3 frames per second, 2 seconds
    tick(); tick();
    chk("t2_time", 32'(s_time), 2);
    tick();
    chk("t3_time", 32'(s_time), 1);
    chk("t3_sel", 32'(s_sel), 1);
    tick(); tick();
    vsync = 1'b1;
    step();
    chk("t6_time", 32'(s_time), 0);
    chk("t6_sel", 32'(s_sel), 2);
    chk("t6_go", 32'(s_go), 1);
    chk("t6_en", 32'(s_en), 0);
    chk("dflt_time_run", 32'(d_time), 30);
    vsync = 1'b0;
    step();

    // Hold-off in OVER: early click ignored, click after 4 ticks returns to IDLE
    tick(); tick();
    press(100, 100);
    chk("early_sel", 32'(s_sel), 2);
    chk("early_go", 32'(s_go), 1);
    release_btn();
    tick(); tick();
    press(100, 100);
    chk("late_sel", 32'(s_sel), 0);
    chk("late_go", 32'(s_go), 0);
    chk("late_score", 32'(s_score), 2);
    release_btn();

    // Hit coincident with the expiring tick
    press(500, 380);
    chk("restart_sel", 32'(s_sel), 1);
    chk("restart_score", 32'(s_score), 0);
    release_btn();
    tick(); tick(); tick(); tick(); tick();
    xpos = 12'd330; ypos = 12'd230;
    vsync = 1'b1; mouse_left = 1'b1;
    step();
    chk("coinc_score", 32'(s_score), 1);
    chk("coinc_sel", 32'(s_sel), 2);
    chk("coinc_rsp", 32'(s_rsp), 0);
    chk("coinc_time", 32'(s_time), 0);
    chk("coinc_dflt_score", 32'(d_score), 3);
    chk("coinc_dflt_rsp", 32'(d_rsp), 1);
    vsync = 1'b0; mouse_left = 1'b0;
    step();

    // Score saturation at 99 while respawns continue
    for (int i = 0; i < 99; i++) begin
      press(330, 230);
      release_btn();
    end
    press(330, 230);
    chk("sat_score", 32'(d_score), 99);
    chk("sat_rsp", 32'(d_rsp), 1);
    chk("over_frozen_score", 32'(s_score), 1);
    chk("over_frozen_sel", 32'(s_sel), 2);
    release_btn();

    // Reset mid-play with a hit pending
    rst = 1'b1;
    press(330, 230);
    chk("midrst_sel", 32'(d_sel), 0);
    chk("midrst_en", 32'(d_en), 0);
    chk("midrst_rsp", 32'(d_rsp), 0);
    chk("midrst_score", 32'(d_score), 0);
    chk("midrst_time", 32'(d_time), 30);
    chk("midrst_go", 32'(d_go), 0);
    chk("midrst_short_time", 32'(s_time), 2);
    rst = 1'b0;
    release_btn();
    chk("post_rst_sel", 32'(d_sel), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
